// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard using the
// request-to-send sequence. Lines are only ever pulled low through the *_OE outputs.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iSend,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DATA_OE,
    output logic       oBusy,
    output logic       oDone,
    output logic       oAck,
    output logic       oError
);

    // state     | meaning
    // S_IDLE    | waiting for iSend
    // S_INHIBIT | clock held low to claim the bus
    // S_START   | clock still low, start bit (data low) asserted
    // S_REQ     | clock released, waiting for the first device falling edge
    // S_BITS    | shifting data, parity and stop on device falling edges
    // S_ACK     | sampling the device acknowledge bit
    // S_WAIT_IDLE | waiting for both lines to return high
    // S_FIN     | one-cycle completion report
    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_REQ,
        S_BITS,
        S_ACK,
        S_WAIT_IDLE,
        S_FIN
    } state_t;

    localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] INH_LOAD = TMR_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [9:0]       shift_q, shift_d;
    logic [3:0]       fe_cnt_q, fe_cnt_d;
    logic             data_oe_q, data_oe_d;
    logic             ack_ok_q, ack_ok_d;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;
    logic fe;
    logic tmo_active;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= iPS2_CLK;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= iPS2_DATA;
            data_sync_q <= data_meta_q;
        end
    end

    assign fe = clk_prev_q & ~clk_sync_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            shift_q   <= '0;
            fe_cnt_q  <= '0;
            data_oe_q <= 1'b0;
            ack_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            fe_cnt_q  <= fe_cnt_d;
            data_oe_q <= data_oe_d;
            ack_ok_q  <= ack_ok_d;
        end
    end

    assign tmo_active = (state_q == S_REQ) || (state_q == S_BITS) ||
                        (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        shift_d   = shift_q;
        fe_cnt_d  = fe_cnt_q;
        data_oe_d = data_oe_q;
        ack_ok_d  = ack_ok_q;

        unique case (state_q)
            S_IDLE: begin
                if (iSend) begin
                    shift_d   = {1'b1, ~^iData, iData};
                    timer_d   = INH_LOAD;
                    fe_cnt_d  = '0;
                    ack_ok_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (timer_q == '0) begin
                    data_oe_d = 1'b1;
                    state_d   = S_START;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            S_START: begin
                timer_d = TO_LOAD;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (fe) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = shift_q >> 1;
                    fe_cnt_d  = fe_cnt_q + 4'd1;
                    state_d   = S_BITS;
                end
            end
            S_BITS: begin
                // The stop bit shifts out as a 1, which releases the data line.
                if (fe) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = shift_q >> 1;
                    fe_cnt_d  = fe_cnt_q + 4'd1;
                    if (fe_cnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (fe) begin
                    ack_ok_d = ~data_sync_q;
                    fe_cnt_d = fe_cnt_q + 4'd1;
                    state_d  = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync_q && data_sync_q) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog on the device clock; any falling edge restarts the window.
        if (tmo_active) begin
            if (fe) begin
                timer_d = TO_LOAD;
            end else if (timer_q == '0) begin
                data_oe_d = 1'b0;
                ack_ok_d  = 1'b0;
                state_d   = S_FIN;
            end else begin
                timer_d = timer_q - TMR_ONE;
            end
        end
    end

    assign oPS2_CLK_OE  = (state_q == S_INHIBIT) || (state_q == S_START);
    assign oPS2_DATA_OE = data_oe_q;
    assign oBusy        = (state_q != S_IDLE);
    assign oDone        = (state_q == S_FIN);
    assign oAck         = (state_q == S_FIN) &  ack_ok_q;
    assign oError       = (state_q == S_FIN) & ~ack_ok_q;

endmodule
